// File: rtl/dip_debounce.sv
// dip_debounce: debounces four asynchronous DIP switch pins.
// Each pin goes through a 2-flop synchronizer and then a per-bit counter that
// must see DEBOUNCE_CYCLES consecutive cycles of a new level before dips_out
// follows. A startup counter holds dips_valid low until the first full
// debounce window after reset has elapsed. change_pulse/changed_mask report
// accepted changes once dips_valid is high.
// Optional build macro DIP_CHG_LATCH_EN adds a sticky chg_flag with a clear
// input chg_clr; without the macro those ports and their logic do not exist.
module dip_debounce #(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int CNT_W           = 18
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] dips_raw,
  output logic [3:0] dips_out,
  output logic       dips_valid,
  output logic       change_pulse,
  output logic [3:0] changed_mask
`ifdef DIP_CHG_LATCH_EN
  ,
  input  logic       chg_clr,
  output logic       chg_flag
`endif
);

  // Last value a per-bit counter may hold; reaching it while still
  // different means the new level has been stable long enough.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // The startup counter must reach DEBOUNCE_CYCLES+1, one bit wider.
  localparam int              SU_W    = CNT_W + 1;
  localparam logic [SU_W-1:0] SU_LAST = SU_W'(DEBOUNCE_CYCLES + 1);

  logic [3:0]      sync_a;
  logic [3:0]      sync_b;
  logic [3:0]      upd;
  logic [SU_W-1:0] su_cnt;

  // Two-stage synchronizer; the only logic that touches dips_raw.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_a <= 4'b1111;
      sync_b <= 4'b1111;
    end else begin
      sync_a <= dips_raw;
      sync_b <= sync_a;
    end
  end

  // One independent debounce counter per switch bit.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      logic [CNT_W-1:0] cnt;
      logic             differ;
      logic             mature;

      assign differ  = sync_b[gi] ^ dips_out[gi];
      assign mature  = differ && (cnt == CNT_LAST);
      assign upd[gi] = mature;

      // Count while the synchronized level disagrees; clear on agreement
      // or when the bit is accepted, so the counter never passes CNT_LAST.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt <= '0;
        end else if (!differ || mature) begin
          cnt <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  endgenerate

  // Accepted bits flip together; a maturing bit always differs, so a flip
  // equals loading the synchronized level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dips_out <= 4'b1111;
    end else begin
      dips_out <= dips_out ^ upd;
    end
  end

  // Startup settle timer: dips_valid rises DEBOUNCE_CYCLES+2 edges after
  // reset release and then stays high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      su_cnt     <= '0;
      dips_valid <= 1'b0;
    end else if (!dips_valid) begin
      if (su_cnt == SU_LAST) begin
        dips_valid <= 1'b1;
      end else begin
        su_cnt <= su_cnt + SU_W'(1);
      end
    end
  end

  // Change strobe, registered alongside dips_out. Gated by the pre-edge
  // dips_valid so an update on the edge where valid rises stays silent.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      change_pulse <= 1'b0;
      changed_mask <= 4'b0000;
    end else begin
      change_pulse <= dips_valid && (upd != 4'b0000);
      changed_mask <= dips_valid ? upd : 4'b0000;
    end
  end

`ifdef DIP_CHG_LATCH_EN
  // Sticky change flag; a pulse beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_flag <= 1'b0;
    end else if (change_pulse) begin
      chg_flag <= 1'b1;
    end else if (chg_clr) begin
      chg_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_dip_debounce.sv
// tb_dip_debounce: directed stimulus with a scoreboard of expected change
// pulses (cycle, mask, dips_out) checked by an independent monitor, plus
// direct checks of reset, dips_valid timing and dips_out levels.
module tb_dip_debounce;
  localparam int D = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] dips_raw = 4'b1111;
  logic [3:0] dips_out;
  logic       dips_valid;
  logic       change_pulse;
  logic [3:0] changed_mask;
`ifdef DIP_CHG_LATCH_EN
  logic       chg_clr = 1'b0;
  logic       chg_flag;
`endif

  dip_debounce #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dips_raw     (dips_raw),
    .dips_out     (dips_out),
    .dips_valid   (dips_valid),
    .change_pulse (change_pulse),
    .changed_mask (changed_mask)
`ifdef DIP_CHG_LATCH_EN
    ,
    .chg_clr      (chg_clr),
    .chg_flag     (chg_flag)
`endif
  );

  always #5 clk = ~clk;

  // Free-running edge counter; after edge k (sampled later) cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] mask;
    logic [3:0] out;
  } exp_t;
  exp_t sb[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Raw change driven now (after edge cyc) must show a pulse at edge cyc+D+2.
  task automatic push(input logic [3:0] mask, input logic [3:0] out);
    exp_t e;
    e.cyc  = cyc + D + 2;
    e.mask = mask;
    e.out  = out;
    sb.push_back(e);
  endtask

  // Monitor: compare every observed pulse against the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (change_pulse) begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_pulse: got mask %b required no pulse (cycle %0d)", changed_mask, cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_mask", {28'b0, changed_mask}, {28'b0, e.mask});
          check("pulse_out", {28'b0, dips_out}, {28'b0, e.out});
        end
      end else if (changed_mask != 4'b0000) begin
        compared++;
        mismatched++;
        $display("FAIL mask_without_pulse: got %b required 0000 (cycle %0d)", changed_mask, cyc);
      end
      if (sb.size() > 0 && sb[0].cyc < cyc) begin
        compared++;
        mismatched++;
        $display("FAIL missed_pulse: got none required mask %b at cycle %0d", sb[0].mask, sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state with switches off.
    rst_n = 1'b0;
    dips_raw = 4'b1111;
    tick(3);
    check("rst_out", {28'b0, dips_out}, 32'hf);
    check("rst_valid", {31'b0, dips_valid}, 0);
    check("rst_pulse", {31'b0, change_pulse}, 0);
    check("rst_mask", {28'b0, changed_mask}, 0);

    // Release; dips_valid rises on the 10th edge.
    rst_n = 1'b1;
    tick(D + 1);
    check("valid_before", {31'b0, dips_valid}, 0);
    check("out_idle", {28'b0, dips_out}, 32'hf);
    tick(1);
    check("valid_rise", {31'b0, dips_valid}, 1);
    tick(3);

    // Clean step on bit0.
    dips_raw = 4'b1110;
    push(4'b0001, 4'b1110);
    tick(D + 1);
    check("bit0_hold", {28'b0, dips_out}, 32'hf);
    tick(1);
    check("bit0_step", {28'b0, dips_out}, 32'he);
    tick(4);

    // Bit2 bounce: 5 low, 1 high, then low held.
    dips_raw = 4'b1010;
    tick(5);
    dips_raw = 4'b1110;
    tick(1);
    dips_raw = 4'b1010;
    push(4'b0100, 4'b1010);
    tick(D + 1);
    check("bit2_hold", {28'b0, dips_out}, 32'he);
    tick(1);
    check("bit2_step", {28'b0, dips_out}, 32'ha);
    tick(3);

    // Bits 1 and 3 on the same edge.
    dips_raw = 4'b0000;
    push(4'b1010, 4'b0000);
    tick(D + 2);
    check("bits13_step", {28'b0, dips_out}, 32'h0);
    tick(3);

    // Glitch of D-1 cycles on bit0 must be rejected.
    dips_raw = 4'b0001;
    tick(D - 1);
    dips_raw = 4'b0000;
    tick(D + 4);
    check("glitch_rejected", {28'b0, dips_out}, 32'h0);

    // Reset at count 5 of a pending bit0 change.
    dips_raw = 4'b0001;
    tick(7);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out", {28'b0, dips_out}, 32'hf);
    check("async_rst_valid", {31'b0, dips_valid}, 0);
    tick(2);
    rst_n = 1'b1;
    tick(D + 1);
    check("rerel_out_hold", {28'b0, dips_out}, 32'hf);
    check("rerel_valid_low", {31'b0, dips_valid}, 0);
    tick(1);
    check("rerel_out_step", {28'b0, dips_out}, 32'h1);
    check("rerel_valid_high", {31'b0, dips_valid}, 1);
    check("rerel_no_pulse", {31'b0, change_pulse}, 0);
    tick(3);

    // Pulses resume after valid.
    dips_raw = 4'b0000;
    push(4'b0001, 4'b0000);
    tick(D + 2);
    check("resume_step", {28'b0, dips_out}, 32'h0);
    tick(3);

`ifdef DIP_CHG_LATCH_EN
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_cleared", {31'b0, chg_flag}, 0);
    dips_raw = 4'b0001;
    push(4'b0001, 4'b0001);
    tick(D + 2);
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_set_wins", {31'b0, chg_flag}, 1);
    tick(1);
    check("flag_sticky", {31'b0, chg_flag}, 1);
    chg_clr = 1'b1;
    tick(1);
    chg_clr = 1'b0;
    check("flag_clear", {31'b0, chg_flag}, 0);
    tick(2);
`endif

    tick(2);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/dip_debounce.md
DIP_DEBOUNCE -- requirements
Module: dip_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 240000, meaning the number of consecutive clk cycles a synchronized input bit must hold a new level before it is accepted (20 ms at 12 MHz); the legal range is 2 to 2^CNT_W-1.
REQ-002 The block SHALL have parameter CNT_W, default 18, meaning the width of each per-bit debounce counter.
REQ-003 The block SHALL have port clk, input, 1 bit: the system clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset; rst_n is asynchronous and active-low, and the clock is clk.
REQ-005 The block SHALL have port dips_raw, input, 4 bits: the DIP switch pins, asynchronous to clk and possibly bouncing.
REQ-006 The block SHALL have port dips_out, output, 4 bits: the debounced switch levels, registered, feeding the LED stage dips_in.
REQ-007 The block SHALL have port dips_valid, output, 1 bit: high once the startup settle period is complete.
REQ-008 The block SHALL have port change_pulse, output, 1 bit: a one-cycle strobe when any dips_out bit changes after dips_valid is high.
REQ-009 The block SHALL have port changed_mask, output, 4 bits: the bits that changed in the cycle of change_pulse, and zero otherwise.

Function
REQ-010 Each dips_raw bit SHALL pass through a 2-flop synchronizer before use; no other logic SHALL read dips_raw.
REQ-011 Per bit, when the synchronized bit differs from the dips_out bit, that bit's counter SHALL increment by one each cycle.
REQ-012 Per bit, when the synchronized bit equals the dips_out bit, that bit's counter SHALL clear to 0 in the next cycle.
REQ-013 Per bit, when the counter equals DEBOUNCE_CYCLES-1 and the bit still differs, the next edge SHALL update the dips_out bit and clear the counter.
REQ-014 A clean level change held at dips_raw SHALL appear on dips_out exactly DEBOUNCE_CYCLES+2 clk edges after the first edge that samples the new level.
REQ-015 A pulse or bounce on dips_raw shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change dips_out.
REQ-016 Each counter SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 The four bits SHALL be independent, and bits maturing in the same cycle SHALL update together.
REQ-018 change_pulse and changed_mask SHALL be registered in the same cycle as the dips_out update.
REQ-019 Bits updating in the same cycle SHALL produce one pulse, with all of those bits set in changed_mask.
REQ-020 A startup counter SHALL hold dips_valid low for DEBOUNCE_CYCLES+2 cycles after reset release, then set dips_valid high, and dips_valid SHALL stay high until the next reset.
REQ-021 While dips_valid is low, dips_out SHALL still debounce normally.
REQ-022 While dips_valid is low, change_pulse and changed_mask SHALL be held at 0.
REQ-023 A dips_out update in the same cycle dips_valid rises SHALL NOT pulse.

Reset
REQ-024 On reset assertion, the block SHALL immediately set dips_out=4'b1111 (switches off, LEDs dark), dips_valid=0, change_pulse=0, changed_mask=0, all counters=0 and both synchronizer stages=4'b1111.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count, and after release the count SHALL restart from 0.
REQ-026 Reset release SHALL be the only exit from the reset state, and the block SHALL need no init sequence.

Configuration
REQ-027 With macro DIP_CHG_LATCH_EN defined, the block SHALL add input chg_clr (1 bit) and output chg_flag (1 bit, reset 0).
REQ-028 With DIP_CHG_LATCH_EN defined, chg_flag SHALL set on the cycle after change_pulse and clear on the cycle after chg_clr=1.
REQ-029 With DIP_CHG_LATCH_EN defined, when change_pulse and chg_clr are both 1 in the same cycle, set SHALL win and chg_flag SHALL be 1.
REQ-030 With DIP_CHG_LATCH_EN undefined, chg_clr, chg_flag and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification (DEBOUNCE_CYCLES=8)
REQ-031 Reset then dips_raw=4'b1111 held -> dips_out=4'b1111; dips_valid rises 10 cycles after release; no change_pulse.
REQ-032 After valid, bit0 steps 1->0 and is held -> dips_out=4'b1110 exactly 10 edges later; one change_pulse with changed_mask=4'b0001.
REQ-033 Bit2 bounces (0 for 5 cycles, 1 for 1 cycle, then 0 held) -> no update during the bounce; dips_out[2]=0 once 8 consecutive synchronized zeros are seen; exactly one pulse.
REQ-034 Bits 1 and 3 change on the same edge -> a single pulse with changed_mask=4'b1010.
REQ-035 Reset asserted at count 5 of a pending bit0 change -> dips_out returns to 4'b1111 at once; after release the change is accepted a full 10 cycles later, with no pulse until dips_valid is high.
REQ-036 With DIP_CHG_LATCH_EN defined, chg_clr pulsed in the same cycle as change_pulse -> chg_flag=1; a later chg_clr alone -> chg_flag=0 next cycle.
